// File: rtl/f1_loader_pkg.sv
// rtl/f1_loader_pkg.sv - shared f1 RAM constants and loader state encoding
package f1_loader_pkg;

    localparam int F1_FRAME_PIX = 1024;
    localparam int F1_AW        = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } f1_state_e;

endpackage

// File: rtl/f1_loader_if.sv
// rtl/f1_loader_if.sv - pixel stream in, f1 RAM port-A write out
interface f1_loader_if #(
    parameter int PIX_W = 8
);
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             pix_ready;
    logic [3:0]       f1_wr_en;
    logic [31:0]      f1_waddr;
    logic [31:0]      f1_wdata;
    logic             f1_ena;

    modport master (
        input  pix_valid, pix_data,
        output pix_ready, f1_wr_en, f1_waddr, f1_wdata, f1_ena
    );

    modport slave (
        output pix_valid, pix_data,
        input  pix_ready, f1_wr_en, f1_waddr, f1_wdata, f1_ena
    );
endinterface

// File: rtl/f1_loader.sv
// rtl/f1_loader.sv - streams one conv1 input frame into f1 RAM, one pixel per 32-bit word
module f1_loader
    import f1_loader_pkg::*;
#(
    parameter int FRAME_PIX = F1_FRAME_PIX,
    parameter int PIX_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        conv1_busy,
    f1_loader_if.master bus,
    output logic        busy,
    output logic        done
);
    localparam int            CW        = $clog2(FRAME_PIX + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_PIX - 1);

    f1_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pix_ready_q, busy_q, done_q, ena_q;
    logic [3:0]       wr_en_q;
    logic [31:0]      waddr_q, wdata_q;
    logic [F1_AW-1:0] widx;
    logic             accept;

    // pix_ready_q is a pure decode of the registered state, so accept never loops back into it
    assign accept = pix_ready_q & bus.pix_valid;
    assign widx   = F1_AW'(cnt_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !conv1_busy) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counter parks at FRAME_PIX after the last beat; only a new start clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pix_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ena_q       <= 1'b0;
            wr_en_q     <= 4'h0;
            waddr_q     <= 32'h0;
            wdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pix_ready_q <= (state_d == ST_LOAD);
            busy_q      <= (state_d == ST_LOAD) || (state_d == ST_FLUSH);
            done_q      <= (state_d == ST_DONE);
            ena_q       <= accept;
            wr_en_q     <= accept ? 4'hF : 4'h0;
            if (accept) begin
                waddr_q <= 32'({widx, 2'b00});
                wdata_q <= {{(32 - PIX_W){1'b0}}, bus.pix_data};
            end
        end
    end

    assign bus.pix_ready = pix_ready_q;
    assign bus.f1_ena    = ena_q;
    assign bus.f1_wr_en  = wr_en_q;
    assign bus.f1_waddr  = waddr_q;
    assign bus.f1_wdata  = wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_f1_loader.sv
// tb/tb_f1_loader.sv - directed vector bench for f1_loader with f1 RAM model
module tb_f1_loader;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic conv1_busy;
    logic busy;
    logic done;

    f1_loader_if #(.PIX_W(8)) bus_if ();

    f1_loader #(.FRAME_PIX(1024), .PIX_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .conv1_busy (conv1_busy),
        .bus        (bus_if.master),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int tests    = 0;
    int fails    = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    logic [17:0] exp_q[$];

    logic [31:0] mem [0:1023];
    logic [9:0]  rd_addr;
    logic [9:0]  rd_addr_q;
    logic [31:0] rd_data;

    typedef struct {
        logic       s;
        logic       cb;
        logic       v;
        logic [7:0] d;
        logic       acc;
        logic [9:0] idx;
        logic [3:0] e_flags;
        logic [31:0] e_addr;
        logic [31:0] e_data;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] outs();
        return {bus_if.pix_ready, busy, done, bus_if.f1_ena,
                bus_if.f1_wr_en, bus_if.f1_waddr, bus_if.f1_wdata};
    endfunction

    function automatic logic [3:0] flags();
        return {bus_if.pix_ready, busy, done, bus_if.f1_ena};
    endfunction

    task automatic add(input logic s, input logic cb, input logic v, input logic [7:0] d,
                       input logic acc, input logic [9:0] idx, input logic [3:0] ef,
                       input logic [31:0] ea, input logic [31:0] ed);
        vec_t r;
        r.s = s; r.cb = cb; r.v = v; r.d = d; r.acc = acc; r.idx = idx;
        r.e_flags = ef; r.e_addr = ea; r.e_data = ed;
        tbl.push_back(r);
    endtask

    // RAM model: byte-enable write, two-cycle registered read
    always @(posedge clk) begin
        if (bus_if.f1_wr_en == 4'hF) mem[bus_if.f1_waddr[11:2]] <= bus_if.f1_wdata;
        rd_addr_q <= rd_addr;
        rd_data   <= mem[rd_addr_q];
    end

    // Write scoreboard: every write must match the next accepted beat
    always @(negedge clk) begin
        logic [17:0] e;
        if (done) done_cnt++;
        if (bus_if.f1_ena) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %h data %h, required no write",
                         bus_if.f1_waddr, bus_if.f1_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write", {bus_if.f1_wr_en, bus_if.f1_waddr, bus_if.f1_wdata},
                      {4'hF, 20'h0, e[17:8], 2'b00, 24'h0, e[7:0]});
            end
        end
    end

    task automatic start_load();
        start      = 1'b1;
        conv1_busy = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_pixels(input int first, input int last, input bit gapped, input int base);
        int n     = first;
        int guard = 0;
        while (n < last && guard < 3000) begin
            bus_if.pix_valid = gapped ? (guard % 2 == 0) : 1'b1;
            bus_if.pix_data  = 8'(n + base);
            @(negedge clk);
            if (bus_if.pix_valid && bus_if.pix_ready) begin
                exp_q.push_back({10'(n), bus_if.pix_data});
                n++;
            end
            @(posedge clk); #1;
            guard++;
        end
        bus_if.pix_valid = 1'b0;
        check("beats_accepted", 72'(n), 72'(last));
    endtask

    // Called just after the final accept edge: FLUSH (last write), DONE, IDLE
    task automatic check_tail(input bit poke);
        start            = poke;
        bus_if.pix_valid = poke;
        @(negedge clk);
        check("tail_flush", 72'(flags()), 72'(4'b0101));
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("tail_done", 72'(flags()), 72'(4'b0010));
        @(negedge clk);
        check("tail_idle", 72'(flags()), 72'(4'b0000));
    endtask

    task automatic readback(input int a, input logic [7:0] e);
        rd_addr = 10'(a);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("readback", 72'(rd_data), 72'({24'h0, e}));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0;
        int d0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rd_addr          = 10'd0;
        rst_n            = 1'b0;
        start            = 1'b0;
        conv1_busy       = 1'b0;
        bus_if.pix_valid = 1'b0;
        bus_if.pix_data  = 8'h00;

        // start, conv1_busy, valid, data, acc, idx, {ready,busy,done,ena}, waddr, wdata
        add(0, 0, 0, 8'h00, 0, 10'd0, 4'b0000, 32'h0, 32'h0);
        add(1, 1, 1, 8'h00, 0, 10'd0, 4'b0000, 32'h0, 32'h0);
        add(0, 1, 1, 8'h00, 0, 10'd0, 4'b0000, 32'h0, 32'h0);
        add(0, 0, 1, 8'h00, 0, 10'd0, 4'b0000, 32'h0, 32'h0);
        add(1, 0, 1, 8'h00, 0, 10'd0, 4'b1100, 32'h0, 32'h0);
        add(0, 1, 1, 8'h00, 1, 10'd0, 4'b1101, 32'h0, 32'h0);
        add(0, 1, 1, 8'h01, 1, 10'd1, 4'b1101, 32'h4, 32'h1);
        add(0, 0, 0, 8'h55, 0, 10'd0, 4'b1100, 32'h4, 32'h1);
        add(1, 0, 1, 8'h02, 1, 10'd2, 4'b1101, 32'h8, 32'h2);

        repeat (2) @(negedge clk);
        check("reset_outputs", outs(), 72'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            start            = tbl[i].s;
            conv1_busy       = tbl[i].cb;
            bus_if.pix_valid = tbl[i].v;
            bus_if.pix_data  = tbl[i].d;
            if (tbl[i].acc) exp_q.push_back({tbl[i].idx, tbl[i].d});
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(),
                  {tbl[i].e_flags, {4{tbl[i].e_flags[0]}}, tbl[i].e_addr, tbl[i].e_data});
        end
        start            = 1'b0;
        conv1_busy       = 1'b0;
        bus_if.pix_valid = 1'b0;
        @(posedge clk); #1;

        // Rest of frame 1 back-to-back, then start/valid poked after the last beat
        drive_pixels(3, 1024, 1'b0, 0);
        check_tail(1'b1);
        repeat (4) @(negedge clk);
        check("extra_valid_ready", 72'(bus_if.pix_ready), 72'(0));
        check("frame1_writes", 72'(wr_cnt), 72'(1024));
        check("frame1_done", 72'(done_cnt), 72'(1));
        bus_if.pix_valid = 1'b0;
        readback(5, 8'h05);
        readback(1023, 8'hFF);

        // Gapped stream
        w0 = wr_cnt;
        d0 = done_cnt;
        start_load();
        drive_pixels(0, 1024, 1'b1, 8'h40);
        check_tail(1'b0);
        check("gapped_writes", 72'(wr_cnt - w0), 72'(1024));
        check("gapped_done", 72'(done_cnt - d0), 72'(1));
        readback(0, 8'h40);
        readback(5, 8'h45);

        // Reset mid-frame after 300 beats
        start_load();
        drive_pixels(0, 300, 1'b0, 8'h20);
        #2;
        rst_n = 1'b0;
        #1;
        check("midframe_reset", outs(), 72'h0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        w0 = wr_cnt;
        start_load();
        drive_pixels(0, 1024, 1'b0, 9);
        check_tail(1'b0);
        check("after_reset_writes", 72'(wr_cnt - w0), 72'(1024));
        readback(0, 8'h09);
        readback(5, 8'h0E);
        check("scoreboard_empty", 72'(exp_q.size()), 72'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
